// File: rtl/operand_fetch.sv
// operand_fetch: sequences the two source-register reads of an issued
// instruction through the single-read-port register file and presents the
// A/B operand pair to the ALU operand registers with a valid/ready handshake.
// Operand B may instead come from the instruction immediate.
//
// Optional feature macro: OPF_BYPASS_EN
//   defined   -> wb_en/wb_addr/wb_data snoop ports exist; a writeback that
//                targets the register being captured overrides rf_rdata.
//   undefined -> operands always come from rf_rdata or the immediate.
//
// Register-file read timing: rf_raddr is registered here and rf_rdata
// carries the addressed value one cycle later, so each read costs an
// address cycle followed by a capture cycle.

module operand_fetch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    input  logic [DATA_W-1:0] imm,
    input  logic              use_imm,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] opa_out,
`ifdef OPF_BYPASS_EN
    output logic [DATA_W-1:0] opb_out,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
`else
    output logic [DATA_W-1:0] opb_out
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_A   = 3'd1,
        ST_RD_B   = 3'd2,
        ST_WAIT_B = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] rf_raddr_q;
    logic [ADDR_W-1:0] src_b_q;
    logic [DATA_W-1:0] imm_q;
    logic              use_imm_q;
    logic              op_valid_q;
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;
    logic [DATA_W-1:0] opa_cap_d;
    logic [DATA_W-1:0] opb_cap_d;

`ifdef OPF_BYPASS_EN
    // src_a is only needed after its address cycle to match against writebacks
    logic [ADDR_W-1:0] src_a_q;
`endif

    assign issue_ready = (state_q == ST_IDLE);
    assign rf_raddr    = rf_raddr_q;
    assign op_valid    = op_valid_q;
    assign opa_out     = opa_q;
    assign opb_out     = opb_q;

    // Select the value captured into each operand: read data, or a coincident writeback
    always_comb begin
        opa_cap_d = rf_rdata;
        opb_cap_d = rf_rdata;
`ifdef OPF_BYPASS_EN
        if (wb_en && (wb_addr == src_a_q)) begin
            opa_cap_d = wb_data;
        end else begin
            opa_cap_d = rf_rdata;
        end
        if (wb_en && (wb_addr == src_b_q)) begin
            opb_cap_d = wb_data;
        end else begin
            opb_cap_d = rf_rdata;
        end
`endif
    end

    // Fetch sequencer: issue latch, read-address sequencing, operand capture and handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rf_raddr_q <= {ADDR_W{1'b0}};
            src_b_q    <= {ADDR_W{1'b0}};
            imm_q      <= {DATA_W{1'b0}};
            use_imm_q  <= 1'b0;
            op_valid_q <= 1'b0;
            opa_q      <= {DATA_W{1'b0}};
            opb_q      <= {DATA_W{1'b0}};
`ifdef OPF_BYPASS_EN
            src_a_q    <= {ADDR_W{1'b0}};
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue_valid) begin
                        src_b_q    <= src_b;
                        imm_q      <= imm;
                        use_imm_q  <= use_imm;
                        rf_raddr_q <= src_a;
`ifdef OPF_BYPASS_EN
                        src_a_q    <= src_a;
`endif
                        state_q    <= ST_RD_A;
                    end
                end
                ST_RD_A: begin
                    // B address goes out even for immediates; the read is simply unused
                    rf_raddr_q <= src_b_q;
                    state_q    <= ST_RD_B;
                end
                ST_RD_B: begin
                    opa_q <= opa_cap_d;
                    if (use_imm_q) begin
                        opb_q      <= imm_q;
                        op_valid_q <= 1'b1;
                        state_q    <= ST_HOLD;
                    end else begin
                        state_q    <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    opb_q      <= opb_cap_d;
                    op_valid_q <= 1'b1;
                    state_q    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (op_ready) begin
                        op_valid_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    op_valid_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed cases plus randomized
// fetches, compared against a register-array reference model. The register
// file is modelled here as a synchronous-read memory behind rf_raddr.
`timescale 1ns/1ps

module tb_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  src_a;
    logic [2:0]  src_b;
    logic [15:0] imm;
    logic        use_imm;
    logic [2:0]  rf_raddr;
    logic [15:0] rf_rdata;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] opa_out;
    logic [15:0] opb_out;
`ifdef OPF_BYPASS_EN
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
`endif

    logic [15:0] regs [0:7];
    int          n_cmp;
    int          n_err;

    operand_fetch #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .src_a       (src_a),
        .src_b       (src_b),
        .imm         (imm),
        .use_imm     (use_imm),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .opa_out     (opa_out),
`ifdef OPF_BYPASS_EN
        .opb_out     (opb_out),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data)
`else
        .opb_out     (opb_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: data for the address presented now appears after the next edge
    always @(posedge clk) rf_rdata <= regs[rf_raddr];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One complete fetch: issue, track reads, check pair and latency, handshake after bp stall cycles
    task automatic fetch(input logic [2:0] a, input logic [2:0] b, input logic [15:0] im,
                         input logic ui, input int bp, input logic byp);
        logic [15:0] ea;
        logic [15:0] eb;
        int          k;
        ea = regs[a];
        eb = ui ? im : regs[b];
`ifdef OPF_BYPASS_EN
        if (byp && !ui) eb = 16'hBEEF;
`else
        if (byp) eb = regs[b];
`endif
        @(negedge clk);
        check_eq("issue_ready_idle", 32'(issue_ready), 32'd1);
        issue_valid = 1'b1; src_a = a; src_b = b; imm = im; use_imm = ui;
        op_ready = (bp == 0);
        @(negedge clk);
        issue_valid = 1'b0;
        src_a = 3'($urandom); src_b = 3'($urandom); imm = 16'($urandom); use_imm = 1'($urandom);
        check_eq("raddr_a", 32'(rf_raddr), 32'(a));
        check_eq("issue_ready_busy", 32'(issue_ready), 32'd0);
        @(negedge clk);
        check_eq("raddr_b", 32'(rf_raddr), 32'(b));
        k = 1;
        while (!op_valid && k < 8) begin
            @(negedge clk);
            k = k + 1;
`ifdef OPF_BYPASS_EN
            wb_en = byp && (k == 2); wb_addr = b; wb_data = 16'hBEEF;
`endif
        end
`ifdef OPF_BYPASS_EN
        wb_en = 1'b0;
`endif
        check_eq("latency", 32'(k), ui ? 32'd2 : 32'd3);
        check_eq("opa", 32'(opa_out), 32'(ea));
        check_eq("opb", 32'(opb_out), 32'(eb));
        check_eq("raddr_hold", 32'(rf_raddr), 32'(b));
        for (int i = 0; i < bp; i++) begin
            issue_valid = 1'b1;
            src_a = 3'($urandom); src_b = 3'($urandom); imm = 16'($urandom);
            @(negedge clk);
            check_eq("bp_valid", 32'(op_valid), 32'd1);
            check_eq("bp_opa", 32'(opa_out), 32'(ea));
            check_eq("bp_opb", 32'(opb_out), 32'(eb));
            check_eq("bp_issue_ready", 32'(issue_ready), 32'd0);
        end
        op_ready = 1'b1;
        @(negedge clk);
        check_eq("hs_valid_drop", 32'(op_valid), 32'd0);
        check_eq("hs_issue_ready", 32'(issue_ready), 32'd1);
        issue_valid = 1'b0;
        op_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; issue_valid = 1'b0; op_ready = 1'b0;
        src_a = 3'd0; src_b = 3'd0; imm = 16'h0000; use_imm = 1'b0;
`ifdef OPF_BYPASS_EN
        wb_en = 1'b0; wb_addr = 3'd0; wb_data = 16'h0000;
`endif
        for (int i = 0; i < 8; i++) regs[i] = 16'(i * 16'h1111);
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(op_valid), 32'd0);
        check_eq("rst_opa", 32'(opa_out), 32'd0);
        check_eq("rst_opb", 32'(opb_out), 32'd0);
        check_eq("rst_raddr", 32'(rf_raddr), 32'd0);
        check_eq("rst_issue_ready", 32'(issue_ready), 32'd1);
        rst_n = 1'b1;

        // Register/register pair
        regs[2] = 16'h1234; regs[5] = 16'hABCD;
        fetch(3'd2, 3'd5, 16'h0000, 1'b0, 0, 1'b0);
        // Immediate operand B
        regs[3] = 16'h0F0F;
        fetch(3'd3, 3'd6, 16'h8001, 1'b1, 0, 1'b0);
        // Backpressure with a competing issue held during the stall
        fetch(3'd5, 3'd2, 16'h0000, 1'b0, 4, 1'b0);
        fetch(3'd3, 3'd1, 16'h7FFF, 1'b1, 4, 1'b0);
        // Same source register
        regs[7] = 16'h5A5A;
        fetch(3'd7, 3'd7, 16'h0000, 1'b0, 0, 1'b0);
        // Writeback coincident with the B capture
        regs[4] = 16'h0000;
        fetch(3'd1, 3'd4, 16'h0000, 1'b0, 1, 1'b1);

        // Reset asserted while waiting for B aborts the fetch
        regs[6] = 16'hC3C3;
        @(negedge clk);
        issue_valid = 1'b1; src_a = 3'd6; src_b = 3'd6; use_imm = 1'b0; op_ready = 1'b0;
        @(negedge clk);
        issue_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(op_valid), 32'd0);
        check_eq("mid_rst_opa", 32'(opa_out), 32'd0);
        check_eq("mid_rst_opb", 32'(opb_out), 32'd0);
        check_eq("mid_rst_issue_ready", 32'(issue_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("post_rst_no_valid", 32'(op_valid), 32'd0);
        end

        // Randomized fetches
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
            fetch(3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), 16'($urandom),
                  1'($urandom_range(1, 0)), int'($urandom_range(3, 0)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand fetch sequencer for the 16-bit RISC datapath. It accepts an issued instruction's source-register indices, reads them one at a time from the single-read-port register file, and presents the A and B operands to the ALU operand registers with a valid/ready handshake. Operand B can come from a sign-free immediate instead of the register file. It sits between instruction decode/issue and the opa/opb operand registers.

## Interface
- DATA_W, 16, operand and register-file data width
- ADDR_W, 3, register index width (8 registers)

- clk  input  1  clock, all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- issue_valid  input  1  issue request present
- issue_ready  output  1  sequencer can accept an issue (combinational, = state IDLE)
- src_a  input  ADDR_W  register index of operand A
- src_b  input  ADDR_W  register index of operand B
- imm  input  DATA_W  immediate value for operand B
- use_imm  input  1  1: operand B = imm, skip register read of src_b
- rf_raddr  output  ADDR_W  register-file read address (registered)
- rf_rdata  input  DATA_W  register-file read data, valid one cycle after rf_raddr
- op_valid  output  1  opa_out/opb_out hold a complete operand pair
- op_ready  input  1  ALU side accepts the pair
- opa_out  output  DATA_W  operand A
- opb_out  output  DATA_W  operand B
- wb_en, wb_addr (ADDR_W), wb_data (DATA_W)  input  writeback snoop; present only with OPF_BYPASS_EN

## Operation
- States: IDLE, RD_A, RD_B, WAIT_B, HOLD.
- IDLE: issue_ready=1. On issue_valid: latch src_b, imm, use_imm; rf_raddr<=src_a; go RD_A.
- RD_A: rf_raddr<=src_b; go RD_B (unconditional; address on bus even if use_imm).
- RD_B: rf_rdata carries reg[src_a]; opa_out<=rf_rdata. If use_imm: opb_out<=imm, op_valid<=1, go HOLD. Else go WAIT_B.
- WAIT_B: rf_rdata carries reg[src_b]; opb_out<=rf_rdata, op_valid<=1, go HOLD.
- HOLD: op_valid=1; opa_out/opb_out stable. On op_ready: op_valid<=0, go IDLE. No new issue accepted in HOLD.
- src_a==src_b: two reads still performed; both operands equal reg value.
- op_ready while op_valid=0: ignored.
- issue_valid while issue_ready=0: ignored; issuer must hold it.
- No arithmetic; data passes unmodified at full DATA_W.

## Timing
- Reset (async assert, sync to clk domain on deassert edge use): state=IDLE, op_valid=0, opa_out=0, opb_out=0, rf_raddr=0, internal latches 0; issue_ready=1.
- Reset mid-operation (any state) aborts the fetch; no partial op_valid ever produced.
- Accept at edge E0 -> op_valid rises at E2 (use_imm=1) or E3 (use_imm=0).
- Handshake completes on the edge where op_valid&&op_ready; earliest next accept is one edge later (IDLE cycle). Throughput: one pair per 4 cycles (imm) / 5 cycles (reg).
- rf_raddr changes only on edges leaving IDLE and RD_A.

## Configuration
- OPF_BYPASS_EN defined: wb_en/wb_addr/wb_data ports exist. At the RD_B capture edge, if wb_en && wb_addr==src_a, opa_out<=wb_data instead of rf_rdata; at the WAIT_B capture edge, if wb_en && wb_addr==src_b, opb_out<=wb_data. Immediate path never bypassed.
- Not defined: ports absent, operands always taken from rf_rdata/imm.

## Test plan
- Reset: rst_n=0 mid-WAIT_B -> op_valid=0, opa_out=opb_out=0000h, issue_ready=1 immediately, no output after release.
- Reg/reg: reg2=1234h, reg5=ABCDh, issue src_a=2, src_b=5, use_imm=0, op_ready=1 -> op_valid high 3 cycles after accept, opa=1234h, opb=ABCDh, rf_raddr sequence 2,5.
- Immediate: reg3=0F0Fh, src_a=3, imm=8001h, use_imm=1 -> op_valid 2 cycles after accept, opa=0F0Fh, opb=8001h.
- Backpressure: op_ready=0 for 4 cycles -> op_valid and operands stable, issue_ready=0, second issue_valid not accepted until one cycle after op_ready=1.
- Same source: src_a=src_b=7, reg7=5A5Ah -> opa=opb=5A5Ah.
- OPF_BYPASS_EN: reg4=0000h, wb_en=1, wb_addr=4, wb_data=BEEFh coincident with WAIT_B, src_b=4 -> opb=BEEFh; without macro opb=0000h.
